// File: rtl/sigmoid_pkg.sv
// Shared constants and state encoding for the sigmoid front-end CORDIC.
// Angle and gain constants are stored in Q2.18, which is the internal format when GUARD=4.
package sigmoid_pkg;

    localparam logic [15:0] ONE_Q14 = 16'd16384;
    localparam logic [14:0] LN2_Q12 = 15'd2839;

    // 1/K_h for the hyperbolic sequence with iterations 4 and 13 repeated.
    localparam logic signed [31:0] KH_INV = 32'sd316538;

    // atanh(2^-i) for i = 1..16, in Q2.18.
    localparam logic [16:1][31:0] ATANH_LUT = {
        32'd4,     32'd8,     32'd16,    32'd32,
        32'd64,    32'd128,   32'd256,   32'd512,
        32'd1024,  32'd2048,  32'd4096,  32'd8195,
        32'd16405, 32'd32940, 32'd66955, 32'd143997
    };

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        ROTATE = 3'd2,
        FINISH = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Rescales a Q2.18 constant to Q2.(14+guard).
    function automatic logic signed [31:0] to_internal(input logic signed [31:0] v,
                                                       input int guard);
        if (guard >= 4)
            return v <<< (guard - 4);
        else
            return v >>> (4 - guard);
    endfunction

endpackage

// File: rtl/cordic_hyp_step.sv
// One combinational hyperbolic CORDIC micro-rotation in rotation mode.
// Both updates of x and y use the incoming (pre-update) values.
module cordic_hyp_step
    import sigmoid_pkg::*;
#(
    parameter int GUARD = 4,
    parameter int CW    = 2 + 14 + GUARD + 1
)
(
    input  logic signed [CW-1:0] x,
    input  logic signed [CW-1:0] y,
    input  logic signed [CW-1:0] z,
    input  logic        [4:0]    i,
    output logic signed [CW-1:0] next_x,
    output logic signed [CW-1:0] next_y,
    output logic signed [CW-1:0] next_z
);

    logic signed [CW-1:0] x_sh;
    logic signed [CW-1:0] y_sh;
    logic signed [CW-1:0] ang;

    always_comb begin
        x_sh = x >>> i;
        y_sh = y >>> i;
        ang  = CW'(to_internal($signed(ATANH_LUT[i]), GUARD));
        // A non-negative residual angle rotates in the positive direction.
        if (!z[CW-1]) begin
            next_x = x + y_sh;
            next_y = y + x_sh;
            next_z = z - ang;
        end else begin
            next_x = x - y_sh;
            next_y = y - x_sh;
            next_z = z + ang;
        end
    end

endmodule

// File: rtl/cordic_exp_front.sv
// Produces num/den for sigmoid(x) = num/den using ln2 range reduction and an iterative
// hyperbolic CORDIC to evaluate e^-|x|; outputs are Q2.14 for the downstream divider.
module cordic_exp_front
    import sigmoid_pkg::*;
#(
    parameter int ITER  = 14,
    parameter int GUARD = 4
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [15:0] num,
    output logic        [15:0] den
);

    localparam int CW = 2 + 14 + GUARD + 1;
    localparam int SW = CW + 1;
    localparam logic signed [CW-1:0] KH_INV_INT = CW'(to_internal(KH_INV, GUARD));
    localparam logic signed [SW-1:0] HALF_LSB   = SW'(1 << (GUARD - 1));
    localparam logic signed [SW-1:0] ONE_WIDE   = SW'(ONE_Q14);
    localparam logic        [4:0]    LAST_ROT   = 5'(ITER + 1);

    state_t               state;
    logic                 neg;
    logic [14:0]          a;
    logic [3:0]           k;
    logic signed [CW-1:0] xc;
    logic signed [CW-1:0] yc;
    logic signed [CW-1:0] zc;
    logic signed [CW-1:0] nx;
    logic signed [CW-1:0] ny;
    logic signed [CW-1:0] nz;
    logic [4:0]           i;
    logic                 rep;
    logic [4:0]           cnt;

    logic [15:0]          neg_x;
    logic [14:0]          a_in;
    logic signed [CW-1:0] r;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;
    logic signed [SW-1:0] rounded;
    logic [15:0]          e;

    assign in_ready = rst_n && (state == IDLE);

    // |x| with the single unrepresentable magnitude (-32768) saturated to 32767.
    always_comb begin
        neg_x = 16'(-x);
        if (x[15])
            a_in = neg_x[15] ? 15'h7FFF : neg_x[14:0];
        else
            a_in = x[14:0];
        r = CW'(a) << (2 + GUARD);
    end

    // x_c + y_c approximates e^-r; undo the range reduction by shifting k places,
    // then round half up on the guard bits. e^-|x| never exceeds 1.0, so clamp.
    always_comb begin
        sum     = SW'(xc) + SW'(yc);
        shifted = sum >>> k;
        rounded = (shifted + HALF_LSB) >>> GUARD;
        if (rounded[SW-1])
            e = 16'd0;
        else if (rounded > ONE_WIDE)
            e = ONE_Q14;
        else
            e = rounded[15:0];
    end

    cordic_hyp_step #(
        .GUARD (GUARD),
        .CW    (CW)
    ) u_step (
        .x      (xc),
        .y      (yc),
        .z      (zc),
        .i      (i),
        .next_x (nx),
        .next_y (ny),
        .next_z (nz)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            num       <= 16'd0;
            den       <= 16'd0;
            neg       <= 1'b0;
            a         <= 15'd0;
            k         <= 4'd0;
            xc        <= '0;
            yc        <= '0;
            zc        <= '0;
            i         <= 5'd1;
            rep       <= 1'b0;
            cnt       <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        neg   <= x[15];
                        a     <= a_in;
                        k     <= 4'd0;
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (a >= LN2_Q12) begin
                        a <= a - LN2_Q12;
                        k <= k + 4'd1;
                    end else begin
                        xc    <= KH_INV_INT;
                        yc    <= '0;
                        zc    <= -r;
                        i     <= 5'd1;
                        rep   <= 1'b0;
                        cnt   <= 5'd0;
                        state <= ROTATE;
                    end
                end
                ROTATE: begin
                    xc  <= nx;
                    yc  <= ny;
                    zc  <= nz;
                    cnt <= cnt + 5'd1;
                    // Iterations 4 and 13 run twice for hyperbolic convergence.
                    if ((i == 5'd4 || i == 5'd13) && !rep) begin
                        rep <= 1'b1;
                    end else begin
                        rep <= 1'b0;
                        i   <= i + 5'd1;
                    end
                    if (cnt == LAST_ROT)
                        state <= FINISH;
                end
                FINISH: begin
                    den       <= ONE_Q14 + e;
                    num       <= neg ? e : ONE_Q14;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_exp_front.sv
// Self-checking bench for cordic_exp_front: directed table, random vectors against an
// exp()-based reference, backpressure and mid-operation reset sequences.
module tb_cordic_exp_front;

    localparam int ITER     = 14;
    localparam int LAT_BASE = ITER + 4;
    localparam int ONE      = 16384;
    localparam int N_RAND   = 30;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x;
    logic               out_valid;
    logic               out_ready;
    logic        [15:0] num;
    logic        [15:0] den;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic signed [15:0] x;
        int                 exp_num;
        int                 exp_den;
        int                 exp_lat;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    cordic_exp_front #(.ITER(ITER), .GUARD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .num       (num),
        .den       (den)
    );

    // Reference: magnitude with saturation, then e^-a straight from the real exponential.
    function automatic int model_a(input logic signed [15:0] xv);
        int a;
        a = (xv < 0) ? -int'(xv) : int'(xv);
        if (a > 32767) a = 32767;
        return a;
    endfunction

    function automatic int model_e(input logic signed [15:0] xv);
        real v;
        v = $exp(-real'(model_a(xv)) / 4096.0) * 16384.0;
        return $rtoi(v + 0.5);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected,
                               input int tol);
        n_checks++;
        if (actual < expected - tol || actual > expected + tol) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (tol %0d)", name, actual, expected, tol);
        end
    endtask

    task automatic applyStimulus(input logic signed [15:0] xv, output int lat,
                                 output int got_num, output int got_den);
        @(negedge clk);
        checkOutput("in_ready_idle", int'(in_ready), 1, 0);
        x        = xv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 80) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid)
            checkOutput("out_valid_timeout", 0, 1, 0);
        got_num = int'(num);
        got_den = int'(den);
    endtask

    task automatic releaseOutput(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_valid_cleared"}, int'(out_valid), 0, 0);
        checkOutput({tag, "_ready_back"}, int'(in_ready), 1, 0);
    endtask

    task automatic checkTxn(input string tag, input logic signed [15:0] xv, input int exp_num,
                            input int exp_den, input int exp_lat);
        int lat;
        int gn;
        int gd;
        applyStimulus(xv, lat, gn, gd);
        checkOutput({tag, "_latency"}, lat, exp_lat, 0);
        checkOutput({tag, "_num"}, gn, exp_num, (xv < 0) ? 4 : 0);
        checkOutput({tag, "_den"}, gd, exp_den, 4);
        if (xv < 0)
            checkOutput({tag, "_num_plus_one_vs_den"}, gn + ONE, gd, 1);
        releaseOutput(tag);
    endtask

    initial begin
        int held_num;
        int held_den;
        int lat;
        int gn;
        int gd;

        vecs[0] = '{16'sd0,      ONE,  32768, 18};
        vecs[1] = '{16'sd4096,   ONE,  22411, 19};
        vecs[2] = '{-16'sd4096,  6027, 22411, 19};
        vecs[3] = '{16'sd32767,  ONE,  16389, 29};
        vecs[4] = '{16'sh8000,   5,    16389, 29};
        vecs[5] = '{16'sd2838,   ONE,  24578, 18};
        vecs[6] = '{-16'sd2839,  8192, 24576, 19};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = 16'sd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", int'(in_ready), 0, 0);
        checkOutput("reset_out_valid", int'(out_valid), 0, 0);
        checkOutput("reset_num", int'(num), 0, 0);
        checkOutput("reset_den", int'(den), 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset_in_ready", int'(in_ready), 1, 0);

        for (int v = 0; v < 7; v++)
            checkTxn($sformatf("vec%0d", v), vecs[v].x, vecs[v].exp_num, vecs[v].exp_den,
                     vecs[v].exp_lat);

        for (int n = 0; n < N_RAND; n++) begin
            logic signed [15:0] xv;
            int e;
            xv = 16'($urandom);
            e  = model_e(xv);
            checkTxn($sformatf("rand%0d_x%0d", n, xv), xv, (xv < 0) ? e : ONE, ONE + e,
                     model_a(xv) / 2839 + LAT_BASE);
        end

        // Backpressure: output must hold while in_valid is asserted with a new x.
        applyStimulus(16'sd4096, lat, gn, gd);
        checkOutput("bp_first_latency", lat, 19, 0);
        held_num = int'(num);
        held_den = int'(den);
        x        = -16'sd4096;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_num_stable", int'(num), held_num, 0);
            checkOutput("bp_den_stable", int'(den), held_den, 0);
            checkOutput("bp_in_ready_low", int'(in_ready), 0, 0);
            checkOutput("bp_out_valid_high", int'(out_valid), 1, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("bp_release_valid", int'(out_valid), 0, 0);
        checkOutput("bp_release_ready", int'(in_ready), 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_no_second_accept", int'(in_ready), 1, 0);
        checkTxn("bp_after", -16'sd4096, 6027, 22411, 19);

        // Reset in the middle of ROTATE aborts without producing a result.
        @(negedge clk);
        x        = 16'sd4096;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_out_valid", int'(out_valid), 0, 0);
        checkOutput("midrst_num", int'(num), 0, 0);
        checkOutput("midrst_den", int'(den), 0, 0);
        checkOutput("midrst_in_ready", int'(in_ready), 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_ready_after", int'(in_ready), 1, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_no_output", int'(out_valid), 0, 0);
        checkTxn("midrst_fresh", 16'sd0, ONE, 32768, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
